wave_pwm_out: RTL and testbench

//   Downstream output stage of the waveform generator. Takes the 8-bit wave sample, applies a

---
 rtl/wave_pwm_out_pkg.sv | 21 ++
 rtl/wave_pwm_out_pwm_cmp.sv | 52 +++++
 rtl/wave_pwm_out.sv | 122 ++++++++++++
 tb/tb_wave_pwm_out.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_pwm_out_pkg.sv
// Shared definitions for the waveform generator output path.
//   WIDTH_DEF  default sample / PWM counter width, shared with the generator
//   AMP_W_DEF  default width of the attenuation select
//   S_*        state encodings of the output-stage FSM
//   pwm_state_e typed view of those encodings
package wave_pwm_out_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AMP_W_DEF = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN
  } pwm_state_e;

endpackage

// File: rtl/wave_pwm_out_pwm_cmp.sv
// PWM period counter, terminal-count flag and compare register.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cnt_en     advance the counter this cycle (wraps at all-ones)
//   cnt_clr    force the counter to zero this cycle (wins over cnt_en)
//   pwm_en     allow pwm_out to go high; when low pwm_out is forced 0
//   duty_next  duty value that applies to the cycle being entered
//   tc         counter is at its terminal value (last clock of the period)
//   pwm_out    registered PWM output
module pwm_cmp
  import wave_pwm_out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             pwm_en,
  input  logic [WIDTH-1:0] duty_next,
  output logic             tc,
  output logic             pwm_out
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (cnt_en) begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign tc = (cnt == {WIDTH{1'b1}});

  // Compare against the *next* count and duty so pwm_out lines up with the
  // registered count with no extra cycle of lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      pwm_out <= pwm_en && (cnt_next < duty_next);
    end
  end

endmodule

// File: rtl/wave_pwm_out.sv
// Output stage of the waveform generator: attenuates the 8-bit sample by a
// selectable right shift and turns it into a PWM stream for an RC-filtered
// pin. One PWM period is 2**WIDTH clocks; a new sample is latched once per
// period and sample_req pulses on that edge so the generator can advance.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          run request
//   wave_in     unsigned sample from the generator
//   amp_sel     attenuation select (right shift amount), sampled at latch
//   pwm_out     registered PWM output
//   sample_req  one-cycle pulse: sample latched on this edge
//   duty_q      currently latched, scaled duty
//   busy        high in RUN or DRAIN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; counter held at 0, pwm_out low
// RUN   | producing PWM, latching a new sample at each period boundary
// DRAIN | en dropped mid-period; finish the period on the old duty, no latch
module wave_pwm_out
  import wave_pwm_out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMP_W = AMP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] wave_in,
  input  logic [AMP_W-1:0] amp_sel,
  output logic             pwm_out,
  output logic             sample_req,
  output logic [WIDTH-1:0] duty_q,
  output logic             busy
);

  pwm_state_e       state;
  pwm_state_e       state_n;
  logic [WIDTH-1:0] scaled;
  logic [WIDTH-1:0] duty_next;
  logic             latch;
  logic             cnt_en;
  logic             cnt_clr;
  logic             pwm_en;
  logic             tc;

  assign scaled = wave_in >> amp_sel;

  // The cycle that latches must already compare against the new duty, so the
  // compare stage sees the scaled sample directly on a latch cycle.
  assign duty_next = latch ? scaled : duty_q;

  // RUN and DRAIN decode identically: with en high the block is running and
  // latches at the period boundary; with en low it finishes the period.
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    pwm_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (en) begin
          state_n = ST_RUN;
          latch   = 1'b1;
          pwm_en  = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (en) begin
          state_n = ST_RUN;
          cnt_en  = 1'b1;
          pwm_en  = 1'b1;
          latch   = tc;
        end else if (tc) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          state_n = ST_DRAIN;
          cnt_en  = 1'b1;
          pwm_en  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      duty_q     <= '0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != ST_IDLE);
      sample_req <= latch;
      if (latch) begin
        duty_q <= scaled;
      end
    end
  end

  pwm_cmp #(
    .WIDTH(WIDTH)
  ) u_pwm_cmp (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .pwm_en   (pwm_en),
    .duty_next(duty_next),
    .tc       (tc),
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_wave_pwm_out.sv
// Bench for wave_pwm_out. Expected latched duties are queued when the
// stimulus that determines them is applied and are consumed whenever the DUT
// pulses sample_req; period-level PWM shape is measured by the main flow.
module tb_wave_pwm_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] wave_in;
  logic [1:0] amp_sel;
  logic       pwm_out;
  logic       sample_req;
  logic [7:0] duty_q;
  logic       busy;

  int         n_chk;
  int         n_pass;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  wave_pwm_out #(.WIDTH(8), .AMP_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wave_in   (wave_in),
    .amp_sel   (amp_sel),
    .pwm_out   (pwm_out),
    .sample_req(sample_req),
    .duty_q    (duty_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on the first cycle of a period; returns once the next latch or
  // IDLE is reached, with high count, leading-high run and period length.
  task automatic measure(output int hi, output int lead, output int len);
    bit still;
    hi    = int'(pwm_out);
    lead  = int'(pwm_out);
    still = pwm_out;
    len   = 1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (sample_req || !busy) return;
      len++;
      if (pwm_out) begin
        hi++;
        if (still) lead++;
      end else begin
        still = 1'b0;
      end
    end
    check("measure_timeout", len, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (sample_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", sample_req, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latch_duty", duty_q, mon_e);
        end
      end
      if (!busy) check("idle_pwm", pwm_out, 0);
    end
  end

  initial begin
    int hi, lead, len, hi_a;
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b0;
    en      = 1'b0;
    wave_in = 8'd0;
    amp_sel = 2'd0;

    repeat (3) tick();
    check("rst_pwm", pwm_out, 0);
    check("rst_busy", busy, 0);
    check("rst_duty", duty_q, 0);
    check("rst_req", sample_req, 0);
    rst = 1'b1;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    // full scale: high 255 of 256
    wave_in = 8'd255; amp_sel = 2'd0;
    exp_q.push_back(8'd255);
    exp_q.push_back(8'd255);
    en = 1'b1;
    tick();
    check("start_req", sample_req, 1);
    check("start_pwm", pwm_out, 1);
    check("start_busy", busy, 1);
    measure(hi, lead, len);
    check("p1_hi", hi, 255);
    check("p1_len", len, 256);
    check("p1_req", sample_req, 1);

    // change mid-run: old duty holds until the next latch
    wave_in = 8'd200; amp_sel = 2'd2;
    exp_q.push_back(8'd50);
    measure(hi, lead, len);
    check("p2_hi", hi, 255);
    check("p3_duty", duty_q, 50);

    wave_in = 8'd0; amp_sel = 2'd0;
    exp_q.push_back(8'd0);
    measure(hi, lead, len);
    check("p3_hi", hi, 50);
    check("p3_lead", lead, 50);
    check("p3_len", len, 256);

    // duty 0, with a mid-period sample change
    hi_a = 0;
    repeat (100) begin hi_a += int'(pwm_out); tick(); end
    wave_in = 8'd128;
    exp_q.push_back(8'd128);
    measure(hi, lead, len);
    check("p4_hi", hi_a + hi, 0);
    check("p4_len", 100 + len, 256);
    exp_q.push_back(8'd128);
    measure(hi, lead, len);
    check("p5_hi", hi, 128);
    check("p5_lead", lead, 128);

    // en drop at cnt=100 -> DRAIN then IDLE
    hi_a = 0;
    repeat (100) begin hi_a += int'(pwm_out); tick(); end
    en = 1'b0;
    measure(hi, lead, len);
    check("drain_hi", hi_a + hi, 128);
    check("drain_len", 100 + len, 256);
    check("drain_busy", busy, 0);
    check("drain_pwm", pwm_out, 0);
    check("drain_req", sample_req, 0);
    repeat (5) tick();
    check("idle_hold", busy, 0);

    // en drop exactly at cnt=255 -> straight to IDLE
    wave_in = 8'd200; amp_sel = 2'd2;
    exp_q.push_back(8'd50);
    en = 1'b1;
    tick();
    check("tc_start_req", sample_req, 1);
    repeat (255) tick();
    check("tc_busy", busy, 1);
    check("tc_pwm_last", pwm_out, 0);
    en = 1'b0;
    tick();
    check("tc_idle", busy, 0);
    check("tc_req", sample_req, 0);
    check("tc_pwm", pwm_out, 0);

    // re-assert en in DRAIN at cnt=180: no restart
    wave_in = 8'd255; amp_sel = 2'd1;
    exp_q.push_back(8'd127);
    en = 1'b1;
    tick();
    repeat (100) tick();
    en = 1'b0;
    repeat (80) tick();
    check("redrain_busy", busy, 1);
    check("redrain_pwm", pwm_out, 0);
    wave_in = 8'd64; amp_sel = 2'd0;
    exp_q.push_back(8'd64);
    en = 1'b1;
    measure(hi, lead, len);
    check("rerun_len", len, 76);
    check("rerun_req", sample_req, 1);
    exp_q.push_back(8'd64);
    measure(hi, lead, len);
    check("p64_hi", hi, 64);
    check("p64_lead", lead, 64);
    check("p64_len", len, 256);

    // async reset mid-period
    repeat (10) tick();
    check("pre_rst_pwm", pwm_out, 1);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    check("arst_pwm", pwm_out, 0);
    check("arst_busy", busy, 0);
    check("arst_duty", duty_q, 0);
    check("arst_req", sample_req, 0);
    #3;
    rst = 1'b1;
    repeat (20) tick();
    check("post_rst_pwm", pwm_out, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_duty", duty_q, 0);
    check("post_rst_req", sample_req, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
